// File: rtl/pipelined_mac.sv
// pipelined_mac: streaming multiply(-accumulate) unit with valid/ready on both sides.
//
// Datapath: input register (operands + tags) -> STAGES product registers ->
// output register (Result / Acc / out_valid). Every register advances together
// whenever the output is empty or being consumed, so in_ready is simply that
// advance condition.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A held
// out_valid is never withdrawn until it transfers; while it is held and
// out_ready is low, the whole pipe freezes, and in_ready is low.
//
// Optional feature: define PIPELINED_MAC_ACCUM_EN to build the running-sum
// accumulator. Without it Acc is tied to zero and clear_acc has no effect.
module pipelined_mac #(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 3,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic                   signed_mode,
    input  logic                   clear_acc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     Result,
    output logic [ACC_WIDTH-1:0]   Acc
);

    localparam int PW = 2*WIDTH;

    // Input register slot
    logic             r_in_vld;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_in_sgn;
    logic             r_in_clr;

    // Product register slots (index 0 is closest to the input)
    logic          r_vld  [STAGES];
    logic [PW-1:0] r_prod [STAGES];
    logic          r_sgn  [STAGES];
    logic          r_clr  [STAGES];

    // Output register
    logic          r_out_vld;
    logic [PW-1:0] r_result;

    logic          w_advance;
    logic [PW-1:0] w_a_ext;
    logic [PW-1:0] w_b_ext;
    logic [PW-1:0] w_prod;

    assign w_advance = !r_out_vld || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_vld;
    assign Result    = r_result;

    // Extending both operands to the full product width makes the low PW bits
    // of a plain unsigned multiply equal to the signed or unsigned product.
    assign w_a_ext = r_in_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_b_ext = r_in_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Capture the operands and per-item tags on every advance (bubbles included)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_in_sgn <= 1'b0;
            r_in_clr <= 1'b0;
        end else if (w_advance) begin
            r_in_vld <= in_valid;
            r_a      <= A;
            r_b      <= B;
            r_in_sgn <= signed_mode;
            r_in_clr <= clear_acc;
        end
    end

    // Shift the product and its tags down the pipe in lock-step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i]  <= 1'b0;
                r_prod[i] <= '0;
                r_sgn[i]  <= 1'b0;
                r_clr[i]  <= 1'b0;
            end
        end else if (w_advance) begin
            r_vld[0]  <= r_in_vld;
            r_prod[0] <= w_prod;
            r_sgn[0]  <= r_in_sgn;
            r_clr[0]  <= r_in_clr;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_prod[i] <= r_prod[i-1];
                r_sgn[i]  <= r_sgn[i-1];
                r_clr[i]  <= r_clr[i-1];
            end
        end
    end

    // Load the output slot; a bubble clears out_valid but leaves Result as is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_result  <= '0;
        end else if (w_advance) begin
            r_out_vld <= r_vld[STAGES-1];
            if (r_vld[STAGES-1]) begin
                r_result <= r_prod[STAGES-1];
            end
        end
    end

`ifdef PIPELINED_MAC_ACCUM_EN
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_prod_ext;

    // Widen the product to the accumulator width following the item's own mode
    assign w_prod_ext = r_sgn[STAGES-1] ? ACC_WIDTH'($signed(r_prod[STAGES-1]))
                                        : ACC_WIDTH'(r_prod[STAGES-1]);
    assign Acc = r_acc;

    // Accumulate (or restart) only when a real item enters the output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_advance && r_vld[STAGES-1]) begin
            if (r_clr[STAGES-1]) begin
                r_acc <= w_prod_ext;
            end else begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end
`else
    logic w_unused_tags;

    // Tags at the end of the pipe only matter to the accumulator
    assign w_unused_tags = r_sgn[STAGES-1] ^ r_clr[STAGES-1];
    assign Acc = '0;
`endif

endmodule

// File: doc/pipelined_mac.md
PIPELINED_MAC -- requirements
Module: pipelined_mac

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (>=2).
REQ-002 Parameter STAGES, default 3, number of product pipeline registers after the input register (>=1).
REQ-003 Parameter ACC_WIDTH, default 2*WIDTH+8, accumulator width (>=2*WIDTH).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  A/B/signed_mode/clear_acc valid this cycle.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 A  input  WIDTH  multiplicand.
REQ-009 B  input  WIDTH  multiplier.
REQ-010 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-011 clear_acc  input  1  this item restarts the accumulator; sampled with the operands.
REQ-012 out_valid  output  1  Result/Acc valid.
REQ-013 out_ready  input  1  consumer accepts output this cycle.
REQ-014 Result  output  2*WIDTH  product of the item at the output.
REQ-015 Acc  output  ACC_WIDTH  running sum including the item at the output.

Function
REQ-016 Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Pipeline of STAGES+1 slots, each holding valid bit, product, clear tag; all slots advance together when advance = !out_valid || out_ready.
REQ-018 in_ready = advance (combinational); with out_ready held 1, one item accepted per cycle, no bubbles inserted.
REQ-019 Latency: item accepted on edge N appears with out_valid=1 after edge N+STAGES+1 when no stall occurs.
REQ-020 While advance=0, all slots, Result, Acc and out_valid hold; out_valid never drops without an output transfer.
REQ-021 Bubbles (in_valid=0 on advance) propagate as invalid slots; they never update Acc.
REQ-022 Product: full 2*WIDTH-bit product, sign-extended operands when signed_mode=1, zero-extended otherwise; no truncation.
REQ-023 Accumulate on load of an item into the output slot: Acc = clear tag ? sext/zext(product) : Acc + ext(product), modulo 2^ACC_WIDTH (wrap, no saturation); extension follows the item's signed_mode.
REQ-024 Items retire strictly in acceptance order; mixed signed/unsigned items in flight are each computed per their own tag.

Reset
REQ-025 rst=1 asynchronously clears all slot valid bits, products, tags, Result, Acc and out_valid to 0.
REQ-026 Reset mid-operation discards all in-flight items; in_ready=1 during and after reset.
REQ-027 First accepted item after reset accumulates onto Acc=0 regardless of clear_acc.

Configuration
REQ-028 Macro PIPELINED_MAC_ACCUM_EN defined: accumulator per REQ-023/REQ-027 is implemented.
REQ-029 Macro absent: no accumulator registers, Acc driven constant 0, clear_acc ignored; all other behaviour identical.

Verification
REQ-030 WIDTH=8, STAGES=3, out_ready=1: A=200,B=150 unsigned -> out_valid 4 cycles later, Result=30000.
REQ-031 Signed: A=8'hFF,B=8'h02 -> Result=16'hFFFE; same operands unsigned next cycle -> Result=16'h01FE next cycle.
REQ-032 Back-to-back 10 items 1..10 times 1, clear_acc on first -> Acc sequence 1,3,6,...,55, no bubbles.
REQ-033 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, Result/Acc/out_valid stable; release -> remaining items drain in order, none lost or duplicated.
REQ-034 ACC_WIDTH=16, repeated 255*255 unsigned -> Acc wraps modulo 65536 (second item Acc=64514).
REQ-035 Assert rst with 3 items in flight -> all outputs 0 immediately; no stale item emerges afterwards; macro-off build -> Acc stays 0 throughout.
